// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Scoreboard-based interlock and call/ret sequencer that sits beside ID.
//   Each of R1..R15 has a countdown of cycles until its pending write is
//   readable by ID. Operand-dependent instructions are held in ID until the
//   countdowns of their sources reach zero. A call/ret that issues freezes
//   fetch and flushes IF/ID until the committed PC update arrives, or until
//   the wait times out.
//
// Parameters
//   WB_LAT      cycles from issue until the write is readable (1..7)
//   CF_TIMEOUT  maximum CF_WAIT cycles before abort (1..255)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_valid                      ID holds a valid instruction
//   id_rs/id_rt/id_rd [3:0]       source register ids in ID
//   id_rs_used/rt_used/rd_used    corresponding field is read as a source
//   id_data_reg                   rs is replaced by R14 (data segment)
//   id_we, id_wr [3:0]            instruction writes register id_wr
//   id_call, id_ret               ID instruction is a call/ret
//   pc_update                     one-cycle pulse: new PC committed
//   stall_fetch                   hold PC and IF/ID
//   bubble                        load NOP into ID/EX
//   flush_ifid                    load NOP into IF/ID
//   busy_mask [15:0]              bit r: register r has a pending write
//   cf_state [1:0]                0=IDLE, 1=CF_WAIT, 2=CF_RESUME
//   cf_timeout                    sticky: a CF_WAIT aborted on timeout
module pipe_stall_ctrl #(
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned CF_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic [3:0]  id_rd,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_rd_used,
  input  logic        id_data_reg,
  input  logic        id_we,
  input  logic [3:0]  id_wr,
  input  logic        id_call,
  input  logic        id_ret,
  input  logic        pc_update,
  output logic        stall_fetch,
  output logic        bubble,
  output logic        flush_ifid,
  output logic [15:0] busy_mask,
  output logic [1:0]  cf_state,
  output logic        cf_timeout
);

  typedef enum logic [1:0] {
    CF_IDLE   = 2'd0,
    CF_WAIT   = 2'd1,
    CF_RESUME = 2'd2
  } cf_state_t;

  localparam logic [2:0] LAT_LOAD = 3'(WB_LAT);
  localparam logic [7:0] TO_LAST  = 8'(CF_TIMEOUT - 1);

  cf_state_t   state_q;
  logic [7:0]  wait_q;
  logic [2:0]  cnt_q [1:15];   // R0 is hard-wired and never tracked

  logic [15:0] busy;
  logic [3:0]  src_a;
  logic        hazard;
  logic        issue;

  assign cf_state = state_q;

  // Hazard detection is purely combinational so a dependent instruction is
  // held in the very cycle it reaches ID.
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < 16; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
    src_a  = id_data_reg ? 4'd14 : id_rs;
    hazard = id_valid &
             (((id_rs_used | id_data_reg) & busy[src_a]) |
              (id_rt_used & busy[id_rt]) |
              (id_rd_used & busy[id_rd]));
    issue  = id_valid & ~hazard & (state_q == CF_IDLE) & ~rst;
  end

  // Strobes and the visible mask are forced low during reset, including a
  // reset that lands in the middle of a call/ret wait.
  always_comb begin
    stall_fetch = 1'b0;
    bubble      = 1'b0;
    flush_ifid  = 1'b0;
    busy_mask   = rst ? '0 : busy;
    if (!rst) begin
      case (state_q)
        CF_IDLE: begin
          stall_fetch = hazard;
          bubble      = hazard;
        end
        CF_WAIT: begin
          stall_fetch = 1'b1;
          bubble      = 1'b1;
          flush_ifid  = 1'b1;
        end
        CF_RESUME: begin
          // Fetch restarts from the new PC; the stale IF/ID entry is dropped.
          bubble      = 1'b1;
          flush_ifid  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < 16; r++) begin
        cnt_q[r] <= '0;
      end
      state_q    <= CF_IDLE;
      wait_q     <= '0;
      cf_timeout <= 1'b0;
    end else begin
      // A new write reloads the full latency, so a WAW pair always resolves
      // to the later producer; the load wins over the same-cycle decrement.
      for (int unsigned r = 1; r < 16; r++) begin
        if (issue && id_we && (id_wr == 4'(r))) begin
          cnt_q[r] <= LAT_LOAD;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 3'd1;
        end
      end

      case (state_q)
        CF_IDLE: begin
          if (issue && (id_call || id_ret)) begin
            state_q <= CF_WAIT;
            wait_q  <= '0;
          end
        end
        CF_WAIT: begin
          wait_q <= wait_q + 8'd1;
          if (pc_update) begin
            state_q <= CF_RESUME;
          end else if (wait_q == TO_LAST) begin
            cf_timeout <= 1'b1;
            state_q    <= CF_IDLE;
          end
        end
        CF_RESUME: state_q <= CF_IDLE;
        default:   state_q <= CF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int WB_LAT     = 3;
  localparam int CF_TIMEOUT = 15;
  localparam int N_RANDOM   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        id_rs_used, id_rt_used, id_rd_used;
  logic        id_data_reg, id_we;
  logic [3:0]  id_wr;
  logic        id_call, id_ret, pc_update;
  logic        stall_fetch, bubble, flush_ifid;
  logic [15:0] busy_mask;
  logic [1:0]  cf_state;
  logic        cf_timeout;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .WB_LAT     (WB_LAT),
    .CF_TIMEOUT (CF_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd_used  (id_rd_used),
    .id_data_reg (id_data_reg),
    .id_we       (id_we),
    .id_wr       (id_wr),
    .id_call     (id_call),
    .id_ret      (id_ret),
    .pc_update   (pc_update),
    .stall_fetch (stall_fetch),
    .bubble      (bubble),
    .flush_ifid  (flush_ifid),
    .busy_mask   (busy_mask),
    .cf_state    (cf_state),
    .cf_timeout  (cf_timeout)
  );

  typedef struct {
    logic        rst, valid;
    logic [3:0]  rs, rt, rd;
    logic        rsu, rtu, rdu, dreg, we;
    logic [3:0]  wr;
    logic        call, ret, pcu;
    logic        es, eb, ef;
    logic [15:0] ebusy;
    logic [1:0]  est;
    logic        etmo;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: time-stamp based. ready[r] is the first cycle number
  // at which register r is readable again; the control-flow wait is tracked
  // by the cycle it started rather than by a counter.
  int cyc = 0;
  int ready [16];
  int mode = 0;          // 0 idle, 1 waiting for PC, 2 resume
  int wstart = 0;
  bit tmo = 1'b0;

  initial for (int i = 0; i < 16; i++) ready[i] = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_busy(input logic [3:0] r);
    return (r != 4'd0) && (ready[r] > cyc);
  endfunction

  function automatic bit m_hazard(input vec_t v);
    logic [3:0] a;
    a = v.dreg ? 4'd14 : v.rs;
    return v.valid && (((v.rsu || v.dreg) && m_busy(a)) ||
                       (v.rtu && m_busy(v.rt)) || (v.rdu && m_busy(v.rd)));
  endfunction

  function automatic vec_t nop();
    vec_t v;
    v = '{rst:0, valid:0, rs:0, rt:0, rd:0, rsu:0, rtu:0, rdu:0, dreg:0, we:0,
          wr:0, call:0, ret:0, pcu:0, es:0, eb:0, ef:0, ebusy:0, est:0, etmo:0};
    return v;
  endfunction

  function automatic vec_t row(input bit r, input bit valid, input int rs, input bit rsu,
                               input int rt, input bit rtu, input bit dreg, input bit we,
                               input int wr, input bit call, input bit es, input logic [15:0] eb);
    vec_t v;
    v = nop();
    v.rst = r; v.valid = valid; v.rs = 4'(rs); v.rsu = rsu; v.rt = 4'(rt); v.rtu = rtu;
    v.dreg = dreg; v.we = we; v.wr = 4'(wr); v.call = call;
    v.es = es; v.eb = es; v.ebusy = eb;
    return v;
  endfunction

  // One clock: drive, compare at the falling edge, advance model at the rising edge.
  task automatic step(input vec_t v, input bit has_exp);
    bit haz, iss, s, b, f;
    logic [15:0] mb;
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rs_used = v.rsu; id_rt_used = v.rtu; id_rd_used = v.rdu; id_data_reg = v.dreg;
    id_we = v.we; id_wr = v.wr; id_call = v.call; id_ret = v.ret; pc_update = v.pcu;
    @(negedge clk);
    haz = m_hazard(v);
    mb = '0;
    for (int r = 1; r < 16; r++) mb[r] = m_busy(4'(r)) && !v.rst;
    s = 0; b = 0; f = 0;
    if (!v.rst) begin
      if (mode == 0) begin s = haz; b = haz; end
      else if (mode == 1) begin s = 1; b = 1; f = 1; end
      else begin b = 1; f = 1; end
    end
    if (has_exp) begin
      chk("tbl_stall", 32'(stall_fetch), 32'(v.es));
      chk("tbl_bubble", 32'(bubble), 32'(v.eb));
      chk("tbl_flush", 32'(flush_ifid), 32'(v.ef));
      chk("tbl_busy", 32'(busy_mask), 32'(v.ebusy));
      chk("tbl_state", 32'(cf_state), 32'(v.est));
      chk("tbl_tmo", 32'(cf_timeout), 32'(v.etmo));
    end
    chk("mdl_stall", 32'(stall_fetch), 32'(s));
    chk("mdl_bubble", 32'(bubble), 32'(b));
    chk("mdl_flush", 32'(flush_ifid), 32'(f));
    chk("mdl_busy", 32'(busy_mask), 32'(mb));
    chk("mdl_state", 32'(cf_state), 32'(mode));
    chk("mdl_tmo", 32'(cf_timeout), 32'(tmo));
    @(posedge clk);
    if (v.rst) begin
      for (int r = 0; r < 16; r++) ready[r] = 0;
      mode = 0; tmo = 0;
    end else begin
      iss = v.valid && !haz && (mode == 0);
      if (iss && v.we && v.wr != 0) ready[v.wr] = cyc + 1 + WB_LAT;
      case (mode)
        0: if (iss && (v.call || v.ret)) begin mode = 1; wstart = cyc + 1; end
        1: if (v.pcu) mode = 2;
           else if (cyc == wstart + CF_TIMEOUT - 1) begin tmo = 1; mode = 0; end
        default: mode = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  function automatic logic [3:0] pick_reg();
    int unsigned k;
    k = $urandom_range(0, 5);
    return (k >= 4) ? 4'd14 : 4'(k);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    tbl.push_back(row(1,0,0,0,0,0,0,0,0,0,0,16'h0000));
    tbl.push_back(row(1,0,0,0,0,0,0,0,0,0,0,16'h0000));
    // R3 producer, dependent reader stalls three cycles
    tbl.push_back(row(0,1,0,0,0,0,0,1,3,0,0,16'h0000));
    tbl.push_back(row(0,1,3,1,0,0,0,0,0,0,1,16'h0008));
    tbl.push_back(row(0,1,3,1,0,0,0,0,0,0,1,16'h0008));
    tbl.push_back(row(0,1,3,1,0,0,0,0,0,0,1,16'h0008));
    tbl.push_back(row(0,1,3,1,0,0,0,0,0,0,0,16'h0000));
    // R0 write then read: never busy
    tbl.push_back(row(0,1,0,0,0,0,0,1,0,0,0,16'h0000));
    tbl.push_back(row(0,1,0,1,0,1,0,0,0,0,0,16'h0000));
    // data-segment substitution
    tbl.push_back(row(0,1,0,0,0,0,0,1,14,0,0,16'h0000));
    tbl.push_back(row(0,1,2,0,0,0,1,0,0,0,1,16'h4000));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h4000));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h4000));
    tbl.push_back(row(0,1,0,0,0,0,0,1,2,0,0,16'h0000));
    tbl.push_back(row(0,1,2,1,0,0,1,0,0,0,0,16'h0004));
    // WAW on R5: second write reloads
    tbl.push_back(row(0,1,0,0,0,0,0,1,5,0,0,16'h0004));
    tbl.push_back(row(0,1,0,0,0,0,0,1,5,0,0,16'h0024));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h0020));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h0020));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h0020));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h0000));
    // call with a hazard stalls and never enters CF_WAIT
    tbl.push_back(row(0,1,0,0,0,0,0,1,7,0,0,16'h0000));
    tbl.push_back(row(0,1,7,1,0,0,0,0,0,1,1,16'h0080));
    tbl.push_back(row(0,1,7,1,0,0,0,0,0,1,1,16'h0080));
    tbl.push_back(row(0,1,7,1,0,0,0,0,0,1,1,16'h0080));
    tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,16'h0000));

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // call, pc_update four cycles later
    v = nop(); v.valid = 1; v.call = 1; step(v, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      v = nop(); v.pcu = (i == 4); v.es = 1; v.eb = 1; v.ef = 1; v.est = 2'd1;
      step(v, 1'b1);
    end
    v = nop(); v.eb = 1; v.ef = 1; v.est = 2'd2; step(v, 1'b1);
    v = nop(); v.pcu = 1; step(v, 1'b1);          // ignored outside CF_WAIT
    v = nop(); step(v, 1'b1);

    // ret with no pc_update times out
    v = nop(); v.valid = 1; v.ret = 1; step(v, 1'b1);
    for (int i = 0; i < CF_TIMEOUT; i++) begin
      v = nop(); v.es = 1; v.eb = 1; v.ef = 1; v.est = 2'd1; step(v, 1'b1);
    end
    v = nop(); v.etmo = 1; step(v, 1'b1);
    v = nop(); v.etmo = 1; step(v, 1'b1);
    v = nop(); v.rst = 1; v.etmo = 1; step(v, 1'b1);
    v = nop(); step(v, 1'b1);

    // reset in the middle of CF_WAIT with a pending write
    v = nop(); v.valid = 1; v.call = 1; v.we = 1; v.wr = 4'd9; step(v, 1'b1);
    v = nop(); v.es = 1; v.eb = 1; v.ef = 1; v.est = 2'd1; v.ebusy = 16'h0200; step(v, 1'b1);
    v = nop(); v.rst = 1; v.est = 2'd1; step(v, 1'b1);
    v = nop(); step(v, 1'b1);

    // randomized traffic against the reference model
    for (int n = 0; n < N_RANDOM; n++) begin
      v = nop();
      v.rst   = ($urandom_range(0, 299) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.rs = pick_reg(); v.rt = pick_reg(); v.rd = pick_reg(); v.wr = pick_reg();
      v.rsu  = 1'($urandom_range(0, 1));
      v.rtu  = 1'($urandom_range(0, 1));
      v.rdu  = ($urandom_range(0, 3) == 0);
      v.dreg = ($urandom_range(0, 7) == 0);
      v.we   = 1'($urandom_range(0, 1));
      v.call = ($urandom_range(0, 15) == 0);
      v.ret  = !v.call && ($urandom_range(0, 15) == 0);
      v.pcu  = ($urandom_range(0, 9) == 0);
      step(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Scoreboard-based pipeline interlock and control-flow sequencer for the 5-stage, 16-register core. It sits beside the ID stage. It tracks in-flight register writes with per-register countdowns and stalls operand-dependent instructions until their writes retire. It also sequences call/ret by freezing fetch, flushing IF/ID and waiting for the committed PC update, and it owns the stall, bubble and flush strobes for the PC, IF/ID and ID/EX registers.

## Interface
- WB_LAT, 3: cycles from issue into ID/EX until the register write is readable by ID; range 1-7.
- CF_TIMEOUT, 15: maximum CF_WAIT cycles before abort; range 1-255.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs, id_rt, id_rd  in  4 each  source register ids in ID.
- id_rs_used, id_rt_used, id_rd_used  in  1 each  the corresponding field is read as a source.
- id_data_reg  in  1  source rs is replaced by R14 (data segment register).
- id_we  in  1  instruction writes register id_wr.
- id_wr  in  4  destination register id.
- id_call, id_ret  in  1  ID instruction is call/ret.
- pc_update  in  1  one-cycle pulse: new PC committed.
- stall_fetch  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX instead of the ID instruction.
- flush_ifid  out  1  load NOP into IF/ID.
- busy_mask  out  16  bit r = register r has a pending write.
- cf_state  out  2  0=IDLE, 1=CF_WAIT, 2=CF_RESUME.
- cf_timeout  out  1  sticky: a CF_WAIT aborted on timeout.

## Operation
- Scoreboard: cnt[r] for r=1..15, 3 bits; R0 is never tracked and is never busy. busy_mask[r] = (cnt[r] != 0).
- src_a = 14 if id_data_reg, else id_rs. Hazard = id_valid & ((id_rs_used|id_data_reg) & busy[src_a] | id_rt_used & busy[id_rt] | id_rd_used & busy[id_rd]).
- issue = id_valid & ~hazard & (cf_state==IDLE) & ~rst.
- Each cycle, every nonzero cnt decrements by 1.
- On issue with id_we & id_wr!=0, cnt[id_wr] <= WB_LAT. A set overrides the same-cycle decrement of that entry. A second write to an already-busy register reloads WB_LAT, so WAW always resolves to the later write.
- IDLE: stall_fetch = bubble = hazard; flush_ifid = 0.
- IDLE, issue & (id_call|id_ret): go to CF_WAIT and clear the wait counter. The call/ret itself issues that cycle; its id_we write is scoreboarded normally. call/ret with a hazard stalls like any other instruction and does not enter CF_WAIT.
- CF_WAIT: stall_fetch=1, bubble=1, flush_ifid=1. The wait counter increments each cycle.
  - On pc_update: go to CF_RESUME.
  - Else, when the wait counter reaches CF_TIMEOUT-1: set cf_timeout and go to IDLE.
  - pc_update takes priority over timeout in the same cycle.
- CF_RESUME: stall_fetch=0, bubble=1, flush_ifid=1, which discards the stale fetch. Next state is always IDLE.
- pc_update outside CF_WAIT is ignored.
- The scoreboard keeps decrementing in all states.

## Timing
- Reset (rst high at a clk edge): all cnt=0, cf_state=IDLE, wait counter=0, cf_timeout=0.
- While rst is high, stall_fetch, bubble and flush_ifid are 0 and busy_mask is 0. The same applies to rst asserted mid-CF_WAIT: return to IDLE with no pending writes.
- Hazard-to-stall latency is 0. Outputs combine registered state with the current ID inputs.
- A dependent instruction issued at cycle t with a producer issued at t-k stalls for max(0, WB_LAT-k+1) cycles.
  - With WB_LAT=3, a back-to-back dependent instruction stalls 3 cycles and issues at t+3.
- A call/ret issued at cycle t gives CF_WAIT from t+1. pc_update at cycle p gives CF_RESUME at p+1 and IDLE at p+2; normal fetch resumes at p+1.
- Timeout: CF_WAIT is entered at t+1 and the state is IDLE at t+1+CF_TIMEOUT. cf_timeout is high from that same cycle.

## Test plan
- R3 write issued, next instruction reads rs=R3 (WB_LAT=3) -> stall_fetch=bubble=1 for 3 cycles, then issue; busy_mask bit 3 goes 1,1,1,0.
- Write to R0, then read R0 -> no stall; busy_mask stays 0.
- id_data_reg=1, rs=R2, R14 busy -> stall; R14 idle and R2 busy -> no stall.
- R5 written twice one cycle apart -> cnt[5] reloads to 3 and busy clears 3 cycles after the second issue.
- call issued, pc_update 4 cycles later -> CF_WAIT for 4 cycles with flush_ifid=1, CF_RESUME for 1 cycle with stall_fetch=0 and flush_ifid=1, then IDLE.
- ret with no pc_update (CF_TIMEOUT=15) -> IDLE after 15 CF_WAIT cycles and cf_timeout=1. A later rst clears cf_timeout, and rst asserted mid-CF_WAIT gives IDLE with all outputs 0.
